// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle controller: opcode constants,
// FSM state encoding, fault codes, the decoded-field bundle and small
// helper functions used by the control logic.
package cpu_pkg;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_J   = 6'b000010;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB     = 3'd4,
    ST_JUMP   = 3'd5,
    ST_HALT   = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    FAULT_NONE    = 2'd0,
    FAULT_ILLEGAL = 2'd1,
    FAULT_TIMEOUT = 2'd2
  } fault_e;

  // Decoded view of an instruction word.
  typedef struct packed {
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [25:0] target;
  } fields_t;

  function automatic logic is_alu_op(input logic [5:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

  // Retired-instruction counter increments but never wraps.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/instr_fields.sv
// Purely combinational instruction field extraction, shared by the
// controller and the datapath.
// Ports:
//   ir_i      instruction register contents
//   fields_o  opcode [31:26], rs [25:21], rt [20:16], rd [15:11],
//             jump target [25:0]
module instr_fields
  import cpu_pkg::*;
(
  input  logic [31:0] ir_i,
  output fields_t     fields_o
);

  assign fields_o.opcode = ir_i[31:26];
  assign fields_o.rs     = ir_i[25:21];
  assign fields_o.rt     = ir_i[20:16];
  assign fields_o.rd     = ir_i[15:11];
  assign fields_o.target = ir_i[25:0];

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle instruction controller: fetches a word over a req/ack
// instruction port, decodes ADD/SUB/J, sequences EXEC/WB or JUMP, keeps
// the program counter and a saturating retired-instruction count, and
// stops in an absorbing HALT state on an illegal opcode or fetch timeout.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   imem_req/addr           fetch request and address (= pc)
//   imem_rdata/ack          fetched word and completion strobe
//   rs/rt/rd_addr           register-file addresses (DECODE/EXEC/WB only)
//   alu_op                  0 add, 1 subtract (SUB in EXEC/WB)
//   rf_we                   one-cycle register-file write pulse in WB
//   pc                      program counter
//   halt, fault_code        sticky fault indication and its cause
//   retired                 retired-instruction count, saturating
module multicycle_ctrl
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic [4:0]  rs_addr,
  output logic [4:0]  rt_addr,
  output logic [4:0]  rd_addr,
  output logic        alu_op,
  output logic        rf_we,
  output logic [31:0] pc,
  output logic        halt,
  output logic [1:0]  fault_code,
  output logic [15:0] retired
);

  localparam bit          TIMEOUT_EN = (ACK_TIMEOUT != 0);
  // Wait-count value seen in the last permitted FETCH cycle.
  localparam logic [15:0] TO_LAST    =
    TIMEOUT_EN ? 16'(ACK_TIMEOUT - 1) : 16'd0;

  state_e      state_q,   state_d;
  logic [31:0] pc_q,      pc_d;
  logic [31:0] ir_q,      ir_d;
  logic [15:0] retired_q, retired_d;
  logic [15:0] wait_q,    wait_d;
  fault_e      fault_q,   fault_d;

  fields_t     fields;
  logic        fields_en;
  logic        is_sub;

  instr_fields u_fields (
    .ir_i     (ir_q),
    .fields_o (fields)
  );

  assign is_sub = (fields.opcode == OP_SUB);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others; IR is an ordinary register,
  // not a memory, so it is reset along with the rest of the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      retired_q <= '0;
      wait_q    <= '0;
      fault_q   <= FAULT_NONE;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
      wait_q    <= wait_d;
      fault_q   <= fault_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    retired_d = retired_q;
    wait_d    = '0;          // only FETCH keeps counting
    fault_d   = fault_q;
    imem_req  = 1'b0;
    rf_we     = 1'b0;
    alu_op    = 1'b0;
    fields_en = 1'b0;

    unique case (state_q)
      ST_IDLE: state_d = ST_FETCH;

      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_d    = imem_rdata;
          state_d = ST_DECODE;
        end else if (TIMEOUT_EN && (wait_q == TO_LAST)) begin
          state_d = ST_HALT;
          fault_d = FAULT_TIMEOUT;
        end else if (TIMEOUT_EN) begin
          wait_d  = wait_q + 16'd1;
        end
      end

      ST_DECODE: begin
        fields_en = 1'b1;
        if (is_alu_op(fields.opcode)) begin
          state_d = ST_EXEC;
        end else if (fields.opcode == OP_J) begin
          state_d = ST_JUMP;
        end else begin
          state_d = ST_HALT;
          fault_d = FAULT_ILLEGAL;
        end
      end

      ST_EXEC: begin
        fields_en = 1'b1;
        alu_op    = is_sub;
        state_d   = ST_WB;
      end

      ST_WB: begin
        fields_en = 1'b1;
        alu_op    = is_sub;
        rf_we     = 1'b1;
        pc_d      = pc_q + 32'd4;   // wraps naturally at 2^32
        retired_d = sat_inc16(retired_q);
        state_d   = ST_FETCH;
      end

      ST_JUMP: begin
        // Pseudo-direct jump: keep the current 256 MB region.
        pc_d      = {pc_q[31:28], fields.target, 2'b00};
        retired_d = sat_inc16(retired_q);
        state_d   = ST_FETCH;
      end

      ST_HALT: state_d = ST_HALT;

      default: state_d = ST_HALT;
    endcase
  end

  // Register addresses are only meaningful while an ALU instruction is in
  // flight; elsewhere they are held at zero.
  assign rs_addr    = fields_en ? fields.rs : 5'd0;
  assign rt_addr    = fields_en ? fields.rt : 5'd0;
  assign rd_addr    = fields_en ? fields.rd : 5'd0;

  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign halt       = (state_q == ST_HALT);
  assign fault_code = fault_q;
  assign retired    = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl. Three instances share all inputs and
// differ only in RESET_PC, so one instruction sequence exercises the
// default start address, a high-region jump and the pc wrap at 2^32.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_rdata;
  logic        imem_ack;

  // Main instance (RESET_PC = 0)
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [4:0]  rs_addr, rt_addr, rd_addr;
  logic        alu_op, rf_we, halt;
  logic [31:0] pc;
  logic [1:0]  fault_code;
  logic [15:0] retired;

  // Jump-region instance (RESET_PC = 1000_0000)
  logic        j_imem_req, j_alu_op, j_rf_we, j_halt;
  logic [31:0] j_imem_addr, j_pc;
  logic [4:0]  j_rs, j_rt, j_rd;
  logic [1:0]  j_fault;
  logic [15:0] j_retired;

  // Wrap instance (RESET_PC = FFFF_FFFC)
  logic        w_imem_req, w_alu_op, w_rf_we, w_halt;
  logic [31:0] w_imem_addr, w_pc;
  logic [4:0]  w_rs, w_rt, w_rd;
  logic [1:0]  w_fault;
  logic [15:0] w_retired;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int we_cnt   = 0;
  int t0;
  logic [31:0] a0;

  localparam logic [31:0] W_ADD = 32'h8022_1800; // rs1 rt2 rd3
  localparam logic [31:0] W_SUB = 32'h8864_2800; // rs3 rt4 rd5
  localparam logic [31:0] W_J   = 32'h0800_0010; // target 0x10
  localparam logic [31:0] W_BAD = 32'hFC00_0000; // opcode 111111

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (rf_we) we_cnt++;

  multicycle_ctrl u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr),
    .alu_op(alu_op), .rf_we(rf_we), .pc(pc), .halt(halt),
    .fault_code(fault_code), .retired(retired)
  );

  multicycle_ctrl #(.RESET_PC(32'h1000_0000)) u_dutj (
    .clk(clk), .rst_n(rst_n),
    .imem_req(j_imem_req), .imem_addr(j_imem_addr),
    .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .rs_addr(j_rs), .rt_addr(j_rt), .rd_addr(j_rd),
    .alu_op(j_alu_op), .rf_we(j_rf_we), .pc(j_pc), .halt(j_halt),
    .fault_code(j_fault), .retired(j_retired)
  );

  multicycle_ctrl #(.RESET_PC(32'hFFFF_FFFC)) u_dutw (
    .clk(clk), .rst_n(rst_n),
    .imem_req(w_imem_req), .imem_addr(w_imem_addr),
    .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .rs_addr(w_rs), .rt_addr(w_rt), .rd_addr(w_rd),
    .alu_op(w_alu_op), .rf_we(w_rf_we), .pc(w_pc), .halt(w_halt),
    .fault_code(w_fault), .retired(w_retired)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_req",    imem_req,   0);
    check("rst_we",     rf_we,      0);
    check("rst_halt",   halt,       0);
    check("rst_fault",  fault_code, 0);
    check("rst_ret",    retired,    0);
    check("rst_rs",     rs_addr,    0);
    check("rst_alu",    alu_op,     0);
    check("rst_pc0",    pc,         32'h0000_0000);
    check("rst_pcj",    j_pc,       32'h1000_0000);
    check("rst_pcw",    w_pc,       32'hFFFF_FFFC);

    // IDLE lasts one cycle after release
    rst_n = 1'b1;
    #1 check("idle_req", imem_req, 0);
    @(negedge clk);
    check("fetch_entry_req", imem_req, 1);

    // ADD, ack in first FETCH cycle
    t0 = cyc;
    check("add_addr", imem_addr, 32'h0);
    imem_ack = 1'b1; imem_rdata = W_ADD;
    @(negedge clk); imem_ack = 1'b0;              // DECODE
    check("add_dec_rs",  rs_addr, 1);
    check("add_dec_rt",  rt_addr, 2);
    check("add_dec_rd",  rd_addr, 3);
    check("add_dec_req", imem_req, 0);
    @(negedge clk);                                // EXEC
    check("add_ex_alu", alu_op, 0);
    check("add_ex_we",  rf_we,  0);
    @(negedge clk);                                // WB
    check("add_wb_we",  rf_we,  1);
    check("add_wb_rd",  rd_addr, 3);
    check("add_wb_ret", retired, 0);
    @(negedge clk);                                // FETCH
    check("add_we_off", rf_we, 0);
    check("add_req",    imem_req, 1);
    check("add_pc0",    pc,   32'h0000_0004);
    check("add_pcw_wrap", w_pc, 32'h0000_0000);
    check("add_pcj",    j_pc, 32'h1000_0004);
    check("add_ret",    retired, 1);
    check("add_we_cnt", we_cnt, 1);
    check("add_lat",    cyc - t0, 4);

    // SUB, ack in the third FETCH cycle
    t0 = cyc; a0 = imem_addr;
    imem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("sub_wait_req",  imem_req, 1);
      check("sub_wait_addr", imem_addr, a0);
    end
    imem_ack = 1'b1; imem_rdata = W_SUB;
    @(negedge clk); imem_ack = 1'b0;              // DECODE
    check("sub_dec_rs",  rs_addr, 3);
    check("sub_dec_rt",  rt_addr, 4);
    check("sub_dec_rd",  rd_addr, 5);
    check("sub_dec_alu", alu_op, 0);
    @(negedge clk);                                // EXEC
    check("sub_ex_alu", alu_op, 1);
    @(negedge clk);                                // WB
    check("sub_wb_alu", alu_op, 1);
    check("sub_wb_we",  rf_we, 1);
    @(negedge clk);                                // FETCH
    check("sub_alu_off", alu_op, 0);
    check("sub_lat",    cyc - t0, 6);
    check("sub_pc0",    pc, 32'h0000_0008);
    check("sub_ret",    retired, 2);
    check("sub_we_cnt", we_cnt, 2);

    // J; a stray ack with an illegal word during DECODE must not reload IR
    t0 = cyc;
    imem_ack = 1'b1; imem_rdata = W_J;
    @(negedge clk);                                // DECODE
    imem_rdata = W_BAD;
    check("j_dec_we", rf_we, 0);
    @(negedge clk); imem_ack = 1'b0;              // JUMP
    check("j_jump_we",   rf_we, 0);
    check("j_jump_req",  imem_req, 0);
    check("j_jump_rs",   rs_addr, 0);
    check("j_jump_halt", halt, 0);
    @(negedge clk);                                // FETCH
    check("j_pcj",    j_pc, 32'h1000_0040);
    check("j_pc0",    pc,   32'h0000_0040);
    check("j_pcw",    w_pc, 32'h0000_0040);
    check("j_ret",    retired, 3);
    check("j_we_cnt", we_cnt, 2);
    check("j_lat",    cyc - t0, 3);

    // Illegal opcode, then further acks while halted
    imem_ack = 1'b1; imem_rdata = W_BAD;
    @(negedge clk);                                // DECODE
    imem_rdata = W_ADD;
    check("ill_dec_halt", halt, 0);
    @(negedge clk);                                // HALT
    check("ill_halt",  halt, 1);
    check("ill_fault", fault_code, 1);
    check("ill_req",   imem_req, 0);
    repeat (3) @(negedge clk);
    check("ill_hold_halt", halt, 1);
    check("ill_hold_req",  imem_req, 0);
    check("ill_hold_we",   rf_we, 0);
    check("ill_hold_pc",   pc, 32'h0000_0040);
    check("ill_hold_ret",  retired, 3);
    check("ill_hold_flt",  fault_code, 1);
    imem_ack = 1'b0;

    // Reset pulse clears the halt asynchronously
    #2 rst_n = 1'b0;
    #1;
    check("rp_halt",  halt, 0);
    check("rp_fault", fault_code, 0);
    check("rp_pc",    pc, 32'h0);
    check("rp_ret",   retired, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check("rp_fetch", imem_req, 1);

    // Fetch timeout: 16 FETCH cycles with no ack
    repeat (15) @(negedge clk);
    check("to_last_req",  imem_req, 1);
    check("to_last_halt", halt, 0);
    @(negedge clk);
    check("to_halt",  halt, 1);
    check("to_fault", fault_code, 2);
    check("to_req",   imem_req, 0);

    // Reset mid-fetch drops imem_req without a clock edge
    rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check("mf_fetch", imem_req, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("mf_req_drop", imem_req, 0);
    @(negedge clk);
    imem_ack = 1'b1; imem_rdata = W_ADD;          // stale ack
    @(negedge clk); rst_n = 1'b1;                  // IDLE, ack still high
    #1 check("mf_idle_req", imem_req, 0);
    @(negedge clk); imem_ack = 1'b0;              // FETCH, stale ack ignored
    check("mf_fetch2_req", imem_req, 1);
    check("mf_fetch2_rs",  rs_addr, 0);
    @(negedge clk);
    check("mf_still_fetch", imem_req, 1);
    check("mf_ret",         retired, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
